// File: rtl/mic_array_pkg.sv
// Shared types and helpers for the multi-line I2S microphone receiver.
package mic_array_pkg;

   typedef enum logic [1:0] {
      SEEK,
      LEFT,
      RIGHT
   } rx_state_t;

   localparam int SLOT_W = 32;

   // Magnitude of a sign-extended sample, clamped so the most negative code maps to max positive.
   function automatic logic [SLOT_W-1:0] abs_sat(input logic [SLOT_W-1:0] s, input int w);
      logic [SLOT_W-1:0] lim;
      logic [SLOT_W-1:0] mag;
      lim = (SLOT_W'(1) << (w - 1)) - SLOT_W'(1);
      mag = s[SLOT_W-1] ? (~s + SLOT_W'(1)) : s;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/mic_peak_meter.sv
// Per-channel peak meter: follows new peaks instantly, otherwise decays exponentially.
module mic_peak_meter
   import mic_array_pkg::*;
#(
   parameter int SAMPLE_W    = 24,
   parameter int DECAY_SHIFT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                update,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [SLOT_W-1:0]   level
);

   logic [SLOT_W-1:0] mag;
   logic [SLOT_W-1:0] decayed;

   assign mag     = abs_sat(SLOT_W'($signed(sample)), SAMPLE_W);
   assign decayed = level - (level >> DECAY_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else if (update) begin
         level <= (mag > decayed) ? mag : decayed;
      end
   end

endmodule

// File: rtl/mic_array_rx.sv
// Receives N_LINES I2S mic lines into 2*N_LINES channels, with peak meters and a channel monitor.
module mic_array_rx
   import mic_array_pkg::*;
#(
   parameter int N_LINES     = 4,
   parameter int SAMPLE_W    = 24,
   parameter int DECAY_SHIFT = 8
) (
   input  logic                            clk_clk,
   input  logic                            reset_reset_n,
   input  logic                            aud_bclk,
   input  logic                            aud_adclrck,
   input  logic [N_LINES-1:0]              din,
   input  logic [$clog2(2*N_LINES+1)-1:0]  chan_sel,
   input  logic                            err_clr,
   output logic [2*N_LINES*SAMPLE_W-1:0]   sample_data,
   output logic                            sample_ready,
   output logic [SLOT_W-1:0]               codec_stream,
   output logic [SLOT_W-1:0]               volume_level,
   output logic                            frame_err
);

   localparam int N_CH   = 2 * N_LINES;
   localparam int CHAN_W = $clog2(N_CH + 1);
   localparam int CNT_W  = $clog2(SAMPLE_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W + 1);

   logic [1:0] bclk_sync;
   logic [1:0] lr_sync;
   logic       bclk_d;
   logic       lr_d;
   logic       bclk_rise;
   logic       lr_rise;
   logic       lr_fall;

   rx_state_t          state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   slot_start;
   logic               slot_full;
   logic               slot_edge;
   logic [SAMPLE_W-1:0] shift_reg [N_LINES];
   logic [SAMPLE_W-1:0] left_hold [N_LINES];

   logic [SAMPLE_W-1:0] ch_sample [N_CH];
   logic [SLOT_W-1:0]   ch_level  [N_CH];
   logic [SAMPLE_W-1:0] sel_sample;
   logic [SLOT_W-1:0]   sel_level;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         bclk_d    <= 1'b0;
         lr_d      <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], aud_bclk};
         lr_sync   <= {lr_sync[0], aud_adclrck};
         bclk_d    <= bclk_sync[1];
         lr_d      <= lr_sync[1];
      end
   end

   assign bclk_rise = bclk_sync[1] & ~bclk_d;
   assign lr_rise   = lr_sync[1] & ~lr_d;
   assign lr_fall   = ~lr_sync[1] & lr_d;

   // A bit clock edge landing with the LR edge is the new slot's delay bit, so it is pre-counted.
   assign slot_start = bclk_rise ? CNT_W'(1) : '0;
   assign slot_full  = (bit_cnt == CNT_FULL);
   assign slot_edge  = ((state == LEFT) && lr_rise) || ((state == RIGHT) && lr_fall);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state        <= SEEK;
         bit_cnt      <= '0;
         sample_ready <= 1'b0;
         frame_err    <= 1'b0;
         sample_data  <= '0;
         for (int k = 0; k < N_LINES; k++) begin
            shift_reg[k] <= '0;
            left_hold[k] <= '0;
         end
      end else begin
         sample_ready <= 1'b0;
         if (err_clr) frame_err <= 1'b0;
         unique case (state)
            SEEK: begin
               if (lr_fall) begin
                  state   <= LEFT;
                  bit_cnt <= slot_start;
               end
            end
            LEFT, RIGHT: begin
               if (slot_edge) begin
                  bit_cnt <= slot_start;
                  if (!slot_full) begin
                     frame_err <= 1'b1;
                     state     <= SEEK;
                  end else if (state == LEFT) begin
                     for (int k = 0; k < N_LINES; k++) left_hold[k] <= shift_reg[k];
                     state <= RIGHT;
                  end else begin
                     for (int k = 0; k < N_LINES; k++) begin
                        sample_data[2*k*SAMPLE_W +: SAMPLE_W]     <= left_hold[k];
                        sample_data[(2*k+1)*SAMPLE_W +: SAMPLE_W] <= shift_reg[k];
                     end
                     sample_ready <= 1'b1;
                     state        <= LEFT;
                  end
               end else if (bclk_rise && !slot_full) begin
                  if (bit_cnt != '0) begin
                     for (int k = 0; k < N_LINES; k++)
                        shift_reg[k] <= {shift_reg[k][SAMPLE_W-2:0], din[k]};
                  end
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: state <= SEEK;
         endcase
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign ch_sample[c] = sample_data[c*SAMPLE_W +: SAMPLE_W];
      mic_peak_meter #(
         .SAMPLE_W   (SAMPLE_W),
         .DECAY_SHIFT(DECAY_SHIFT)
      ) u_meter (
         .clk   (clk_clk),
         .rst_n (reset_reset_n),
         .update(sample_ready),
         .sample(ch_sample[c]),
         .level (ch_level[c])
      );
   end

   // Out-of-range selects match no channel and fall through to zero.
   always_comb begin
      sel_sample = '0;
      sel_level  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (chan_sel == CHAN_W'(c)) begin
            sel_sample = ch_sample[c];
            sel_level  = ch_level[c];
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         codec_stream <= '0;
         volume_level <= '0;
      end else begin
         codec_stream <= SLOT_W'($signed(sel_sample));
         volume_level <= sel_level;
      end
   end

endmodule

// File: tb/tb_mic_array_rx.sv
// Directed bench for mic_array_rx: drives I2S frames on four lines and checks capture, meters and errors.
module tb_mic_array_rx;

   localparam int HALF_BIT = 163;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         bclk     = 1'b0;
   logic         lrck     = 1'b1;
   logic [3:0]   din      = '0;
   logic [3:0]   chan_sel = '0;
   logic         err_clr  = 1'b0;
   logic [191:0] sample_data;
   logic         sample_ready;
   logic [31:0]  codec_stream;
   logic [31:0]  volume_level;
   logic         frame_err;

   int n_compared   = 0;
   int n_mismatched = 0;
   int ready_cnt    = 0;

   mic_array_rx #(
      .N_LINES    (4),
      .SAMPLE_W   (24),
      .DECAY_SHIFT(8)
   ) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .aud_bclk     (bclk),
      .aud_adclrck  (lrck),
      .din          (din),
      .chan_sel     (chan_sel),
      .err_clr      (err_clr),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .codec_stream (codec_stream),
      .volume_level (volume_level),
      .frame_err    (frame_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (sample_ready === 1'b1) ready_cnt++;

   function automatic logic [23:0] ch(input int c);
      return sample_data[c*24 +: 24];
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; din = '0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_bit(input logic lr, input logic [3:0] d);
      bclk = 1'b0; lrck = lr; din = d;
      #HALF_BIT;
      bclk = 1'b1;
      #HALF_BIT;
   endtask

   task automatic send_data(input logic lr, input logic [95:0] v, input int nbits);
      logic [3:0] d;
      for (int b = 23; b > 23 - nbits; b--) begin
         for (int k = 0; k < 4; k++) d[k] = v[k*24 + b];
         send_bit(lr, d);
      end
   endtask

   task automatic send_pad(input logic lr);
      repeat (7) send_bit(lr, 4'h0);
   endtask

   task automatic start_bit();
      send_bit(1'b0, 4'hF);
   endtask

   task automatic send_frame(input logic [95:0] l, input logic [95:0] r);
      send_data(1'b0, l, 24);
      send_pad(1'b0);
      send_bit(1'b1, 4'hF);
      send_data(1'b1, r, 24);
      send_pad(1'b1);
   endtask

   task automatic coincident_fall();
      bclk = 1'b0;
      #HALF_BIT;
      bclk = 1'b1; lrck = 1'b0; din = 4'hF;
      #HALF_BIT;
   endtask

   task automatic test_reset();
      apply_reset();
      n_compared++; if (sample_data !== '0) begin n_mismatched++; $display("[TB] FAIL reset_data: observed %h, required 0", sample_data); end
      n_compared++; if (sample_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready: observed %b, required 0", sample_ready); end
      n_compared++; if (codec_stream !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_codec: observed %h, required 0", codec_stream); end
      n_compared++; if (volume_level !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_volume: observed %h, required 0", volume_level); end
      n_compared++; if (frame_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: observed %b, required 0", frame_err); end
   endtask

   task automatic test_full_scale();
      int r0;
      apply_reset();
      chan_sel = 4'd1;
      r0 = ready_cnt;
      start_bit();
      send_frame({24'h0, 24'h0, 24'h123456, 24'h7FFFFF}, {24'hABCDEF, 24'h0, 24'h0, 24'h800000});
      n_compared++; if (ready_cnt !== r0) begin n_mismatched++; $display("[TB] FAIL early_ready: observed %0d, required %0d", ready_cnt, r0); end
      start_bit();
      n_compared++; if (ready_cnt !== r0 + 1) begin n_mismatched++; $display("[TB] FAIL ready_once: observed %0d, required %0d", ready_cnt, r0 + 1); end
      n_compared++; if (ch(0) !== 24'h7FFFFF) begin n_mismatched++; $display("[TB] FAIL ch0: observed %h, required 7fffff", ch(0)); end
      n_compared++; if (ch(1) !== 24'h800000) begin n_mismatched++; $display("[TB] FAIL ch1: observed %h, required 800000", ch(1)); end
      n_compared++; if (ch(2) !== 24'h123456) begin n_mismatched++; $display("[TB] FAIL ch2: observed %h, required 123456", ch(2)); end
      n_compared++; if (ch(7) !== 24'hABCDEF) begin n_mismatched++; $display("[TB] FAIL ch7: observed %h, required abcdef", ch(7)); end
      n_compared++; if (codec_stream !== 32'hFF800000) begin n_mismatched++; $display("[TB] FAIL codec_ch1: observed %h, required ff800000", codec_stream); end
      n_compared++; if (volume_level !== 32'h007FFFFF) begin n_mismatched++; $display("[TB] FAIL volume_ch1: observed %h, required 007fffff", volume_level); end
      chan_sel = 4'd0;
      repeat (2) @(negedge clk);
      n_compared++; if (codec_stream !== 32'h007FFFFF) begin n_mismatched++; $display("[TB] FAIL codec_ch0: observed %h, required 007fffff", codec_stream); end
      n_compared++; if (volume_level !== 32'h007FFFFF) begin n_mismatched++; $display("[TB] FAIL volume_ch0: observed %h, required 007fffff", volume_level); end
   endtask

   task automatic test_peak_decay();
      apply_reset();
      chan_sel = 4'd0;
      start_bit();
      send_frame({72'h0, 24'h400000}, 96'h0);
      start_bit();
      n_compared++; if (volume_level !== 32'h00400000) begin n_mismatched++; $display("[TB] FAIL peak_attack: observed %h, required 00400000", volume_level); end
      send_frame(96'h0, 96'h0);
      start_bit();
      n_compared++; if (volume_level !== 32'h003FC000) begin n_mismatched++; $display("[TB] FAIL peak_decay1: observed %h, required 003fc000", volume_level); end
      send_frame(96'h0, 96'h0);
      start_bit();
      n_compared++; if (volume_level !== 32'h003F8040) begin n_mismatched++; $display("[TB] FAIL peak_decay2: observed %h, required 003f8040", volume_level); end
   endtask

   task automatic test_negative_full_scale();
      apply_reset();
      chan_sel = 4'd0;
      start_bit();
      send_frame({72'h0, 24'h800000}, 96'h0);
      start_bit();
      n_compared++; if (volume_level !== 32'h007FFFFF) begin n_mismatched++; $display("[TB] FAIL neg_volume: observed %h, required 007fffff", volume_level); end
      n_compared++; if (codec_stream !== 32'hFF800000) begin n_mismatched++; $display("[TB] FAIL neg_codec: observed %h, required ff800000", codec_stream); end
      chan_sel = 4'd8;
      repeat (2) @(negedge clk);
      n_compared++; if (codec_stream !== 32'h0) begin n_mismatched++; $display("[TB] FAIL sel8_codec: observed %h, required 0", codec_stream); end
      n_compared++; if (volume_level !== 32'h0) begin n_mismatched++; $display("[TB] FAIL sel8_volume: observed %h, required 0", volume_level); end
   endtask

   task automatic test_reset_mid_frame();
      int r0;
      apply_reset();
      chan_sel = 4'd0;
      start_bit();
      send_frame({72'h0, 24'h123456}, 96'h0);
      start_bit();
      send_data(1'b0, {72'h0, 24'h0F0F0F}, 10);
      rst_n = 1'b0;
      @(negedge clk);
      n_compared++; if (sample_data !== '0) begin n_mismatched++; $display("[TB] FAIL mid_reset_data: observed %h, required 0", sample_data); end
      n_compared++; if (codec_stream !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_codec: observed %h, required 0", codec_stream); end
      n_compared++; if (volume_level !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_volume: observed %h, required 0", volume_level); end
      n_compared++; if (sample_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_ready: observed %b, required 0", sample_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      r0 = ready_cnt;
      send_data(1'b0, {72'h0, 24'h0F0F0F}, 14);
      send_pad(1'b0);
      send_bit(1'b1, 4'hF);
      send_data(1'b1, 96'h0, 24);
      send_pad(1'b1);
      start_bit();
      n_compared++; if (ready_cnt !== r0) begin n_mismatched++; $display("[TB] FAIL post_reset_early: observed %0d, required %0d", ready_cnt, r0); end
      send_frame({72'h0, 24'h0ABCDE}, 96'h0);
      start_bit();
      n_compared++; if (ready_cnt !== r0 + 1) begin n_mismatched++; $display("[TB] FAIL post_reset_ready: observed %0d, required %0d", ready_cnt, r0 + 1); end
      n_compared++; if (ch(0) !== 24'h0ABCDE) begin n_mismatched++; $display("[TB] FAIL post_reset_ch0: observed %h, required 0abcde", ch(0)); end
   endtask

   task automatic test_short_slot();
      int r0;
      apply_reset();
      start_bit();
      send_frame({72'h0, 24'h111111}, {72'h0, 24'h222222});
      start_bit();
      r0 = ready_cnt;
      send_data(1'b0, {72'h0, 24'h333333}, 16);
      send_bit(1'b1, 4'hF);
      n_compared++; if (frame_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL short_err_set: observed %b, required 1", frame_err); end
      send_data(1'b1, {72'h0, 24'h444444}, 24);
      send_pad(1'b1);
      start_bit();
      n_compared++; if (ready_cnt !== r0) begin n_mismatched++; $display("[TB] FAIL short_no_ready: observed %0d, required %0d", ready_cnt, r0); end
      n_compared++; if (ch(0) !== 24'h111111) begin n_mismatched++; $display("[TB] FAIL short_hold_ch0: observed %h, required 111111", ch(0)); end
      n_compared++; if (ch(1) !== 24'h222222) begin n_mismatched++; $display("[TB] FAIL short_hold_ch1: observed %h, required 222222", ch(1)); end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      @(negedge clk);
      n_compared++; if (frame_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL err_clr: observed %b, required 0", frame_err); end
      send_frame({72'h0, 24'h555555}, {72'h0, 24'h666666});
      start_bit();
      n_compared++; if (ready_cnt !== r0 + 1) begin n_mismatched++; $display("[TB] FAIL resume_ready: observed %0d, required %0d", ready_cnt, r0 + 1); end
      n_compared++; if (ch(0) !== 24'h555555) begin n_mismatched++; $display("[TB] FAIL resume_ch0: observed %h, required 555555", ch(0)); end
      n_compared++; if (ch(1) !== 24'h666666) begin n_mismatched++; $display("[TB] FAIL resume_ch1: observed %h, required 666666", ch(1)); end
   endtask

   task automatic test_coincident_edge();
      int r0;
      apply_reset();
      r0 = ready_cnt;
      coincident_fall();
      send_frame({72'h0, 24'hA5A5A5}, {72'h0, 24'h5A5A5A});
      coincident_fall();
      #HALF_BIT;
      n_compared++; if (ready_cnt !== r0 + 1) begin n_mismatched++; $display("[TB] FAIL coinc_ready: observed %0d, required %0d", ready_cnt, r0 + 1); end
      n_compared++; if (ch(0) !== 24'hA5A5A5) begin n_mismatched++; $display("[TB] FAIL coinc_ch0: observed %h, required a5a5a5", ch(0)); end
      n_compared++; if (ch(1) !== 24'h5A5A5A) begin n_mismatched++; $display("[TB] FAIL coinc_ch1: observed %h, required 5a5a5a", ch(1)); end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_peak_decay();
      test_negative_full_scale();
      test_reset_mid_frame();
      test_short_slot();
      test_coincident_edge();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
